// File: rtl/static_buff_pkg.sv
// ---------------------------------------------------------------------------
// static_buff_pkg
//
// Shared constants and helpers for the static multi-FIFO buffer scheduler.
//
// Contents:
//   DEF_NUMELEM / DEF_BITDATA / DEF_NUMFIFO : default geometry of the buffer
//   arb_mode_e                             : pop arbitration flavour
//   idx_bits(n)                            : width of an index into n items
//   cnt_bits(n)                            : width of a counter holding 0..n
// ---------------------------------------------------------------------------
package static_buff_pkg;

   localparam int DEF_NUMELEM = 4;
   localparam int DEF_BITDATA = 4;
   localparam int DEF_NUMFIFO = 8;

   typedef enum logic {
      ARB_ROUND_ROBIN = 1'b0,
      ARB_STRICT_PRIO = 1'b1
   } arb_mode_e;

   // An index needs at least one bit, even when there is only one item.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // One extra bit so a counter can represent the full value n without wrapping.
   function automatic int cnt_bits(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/static_buff_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational arbiter over N requesters. In round-robin mode the
// search starts at the requester just after ptr and wraps around, so the
// last winner has the lowest priority. In strict mode the pointer is ignored
// and the lowest index wins.
//
// Ports:
//   req       in  N     request vector
//   ptr       in  BITN  last granted index (round-robin reference)
//   strict    in  1     1 = fixed priority, index 0 highest
//   grant     out N     one-hot grant
//   grant_idx out BITN  encoded grant index
//   grant_vld out 1     at least one requester was granted
// ---------------------------------------------------------------------------
module rr_arbiter
   import static_buff_pkg::*;
#(
   parameter int N = DEF_NUMFIFO,
   localparam int BITN = idx_bits(N)
) (
   input  logic [N-1:0]    req,
   input  logic [BITN-1:0] ptr,
   input  logic            strict,
   output logic [N-1:0]    grant,
   output logic [BITN-1:0] grant_idx,
   output logic            grant_vld
);

   // Walk the candidates in priority order and keep the first requester.
   // In round-robin mode candidate k is (ptr + k) mod N for k = 1..N, so
   // the pointer itself is visited last. The wrap is a single subtraction
   // because ptr < N and k <= N, which keeps this valid for non-power-of-2 N.
   always_comb begin
      int              sum;
      logic [BITN-1:0] cand;
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      sum       = 0;
      cand      = '0;
      for (int k = 1; k <= N; k++) begin
         if (strict) begin
            sum = k - 1;
         end else begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
               sum = sum - N;
            end
         end
         cand = BITN'(sum);
         if (!grant_vld && req[cand]) begin
            grant_vld   = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/static_buff_sched.sv
// ---------------------------------------------------------------------------
// static_buff_sched
//
// Flow-control and scheduling front-end for a statically partitioned
// multi-FIFO buffer of NUMFIFO queues with NUMELEM entries each. The block
// keeps a shadow occupancy count per queue, so it only pushes into queues
// that have room and only pops from queues that hold data. One non-empty
// queue per cycle is popped into a single registered output entry with a
// valid/ready handshake.
//
// The external buffer must be reset by the same rst so that its contents
// and the shadow counts agree after reset.
//
// Build option:
//   SCHED_STRICT_PRIO_EN  defined   : pop grant is the lowest-index
//                                     non-empty queue; RR pointer frozen.
//                         undefined : round-robin starting after the
//                                     last granted queue.
//
// Ports:
//   clk          in  1        clock
//   rst          in  1        asynchronous, active-high reset
//   buf_ready    in  1        buffer ready; no push or pop while low
//   in_vld       in  1        enqueue request
//   in_prt       in  BITFIFO  target queue
//   in_din       in  BITDATA  enqueue data
//   in_rdy       out 1        enqueue accepted this cycle (combinational)
//   buf_push     out 1        push strobe to buffer
//   buf_pu_prt   out BITFIFO  push queue id
//   buf_pu_din   out BITDATA  push data
//   buf_pop      out 1        pop strobe to buffer
//   buf_po_prt   out BITFIFO  pop queue id
//   buf_po_dout  in  BITDATA  buffer head data for buf_po_prt
//   out_vld      out 1        output entry valid (registered)
//   out_rdy      in  1        downstream ready
//   out_prt      out BITFIFO  queue id of output entry
//   out_dout     out BITDATA  output data
//   q_empty      out NUMFIFO  per-queue count == 0
//   q_full       out NUMFIFO  per-queue count == NUMELEM
// ---------------------------------------------------------------------------
module static_buff_sched
   import static_buff_pkg::*;
#(
   parameter int NUMELEM = DEF_NUMELEM,
   parameter int BITDATA = DEF_BITDATA,
   parameter int NUMFIFO = DEF_NUMFIFO,
   localparam int BITELEM = $clog2(NUMELEM),
   localparam int BITFIFO = idx_bits(NUMFIFO)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               buf_ready,
   input  logic               in_vld,
   input  logic [BITFIFO-1:0] in_prt,
   input  logic [BITDATA-1:0] in_din,
   output logic               in_rdy,
   output logic               buf_push,
   output logic [BITFIFO-1:0] buf_pu_prt,
   output logic [BITDATA-1:0] buf_pu_din,
   output logic               buf_pop,
   output logic [BITFIFO-1:0] buf_po_prt,
   input  logic [BITDATA-1:0] buf_po_dout,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [BITFIFO-1:0] out_prt,
   output logic [BITDATA-1:0] out_dout,
   output logic [NUMFIFO-1:0] q_empty,
   output logic [NUMFIFO-1:0] q_full
);

   localparam int                 BITCNT    = BITELEM + 1;
   localparam logic [BITCNT-1:0]  CNT_FULL  = BITCNT'(NUMELEM);
   localparam logic [BITCNT-1:0]  CNT_ONE   = BITCNT'(1);
   localparam logic [BITFIFO-1:0] PTR_RESET = BITFIFO'(NUMFIFO - 1);

`ifdef SCHED_STRICT_PRIO_EN
   localparam arb_mode_e ARB_MODE = ARB_STRICT_PRIO;
`else
   localparam arb_mode_e ARB_MODE = ARB_ROUND_ROBIN;
`endif

   logic [BITCNT-1:0]  count [NUMFIFO];
   logic [BITFIFO-1:0] rr_ptr;
   logic [NUMFIFO-1:0] eligible;
   logic [NUMFIFO-1:0] grant;
   logic [NUMFIFO-1:0] push_vec;
   logic [NUMFIFO-1:0] pop_vec;
   logic [BITFIFO-1:0] grant_idx;
   logic               grant_vld;
   logic               prt_in_range;
   logic               take;
   logic               strict;

   assign strict = (ARB_MODE == ARB_STRICT_PRIO);

   // Queue ids beyond NUMFIFO-1 are only representable when NUMFIFO is not
   // a power of two; in that case they must never be accepted.
   generate
      if ((1 << BITFIFO) == NUMFIFO) begin : g_prt_full_range
         assign prt_in_range = 1'b1;
      end else begin : g_prt_partial_range
         assign prt_in_range = (int'(in_prt) < NUMFIFO);
      end
   endgenerate

   // Per-queue status flags straight from the shadow counts. A queue is
   // eligible for popping only if its count at the start of the cycle is
   // non-zero, so a push is never forwarded to the pop side in the same
   // cycle.
   always_comb begin
      q_empty = '0;
      q_full  = '0;
      for (int i = 0; i < NUMFIFO; i++) begin
         q_empty[i] = (count[i] == '0);
         q_full[i]  = (count[i] == CNT_FULL);
      end
   end

   assign eligible = ~q_empty;

   // Enqueue acceptance looks only at the registered full flag. A full
   // queue refuses the push even if it is being popped this very cycle,
   // which keeps in_rdy independent of the pop arbitration.
   always_comb begin
      in_rdy = 1'b0;
      if (buf_ready && prt_in_range) begin
         in_rdy = !q_full[in_prt];
      end
   end

   assign buf_push   = in_vld && in_rdy;
   assign buf_pu_prt = in_prt;
   assign buf_pu_din = in_din;

   rr_arbiter #(
      .N (NUMFIFO)
   ) u_arb (
      .req       (eligible),
      .ptr       (rr_ptr),
      .strict    (strict),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // A pop is issued only when the buffer is ready, some queue holds data
   // and the output entry is free or leaving this cycle.
   assign take       = buf_ready && grant_vld && (!out_vld || out_rdy);
   assign buf_pop    = take;
   assign buf_po_prt = grant_idx;

   // One-hot push and pop vectors used to update the counts in parallel.
   always_comb begin
      push_vec = '0;
      if (buf_push) begin
         push_vec[in_prt] = 1'b1;
      end
      pop_vec = take ? grant : '0;
   end

   // Shadow occupancy. A simultaneous push and pop on the same queue
   // cancels out. Because pushes are gated by q_full and pops by q_empty,
   // the counts stay within 0..NUMELEM and never wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUMFIFO; i++) begin
            count[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUMFIFO; i++) begin
            case ({push_vec[i], pop_vec[i]})
               2'b10:   count[i] <= count[i] + CNT_ONE;
               2'b01:   count[i] <= count[i] - CNT_ONE;
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   // Round-robin pointer remembers the last granted queue. Resetting it to
   // NUMFIFO-1 makes queue 0 the first one searched. With strict priority
   // the pointer is never advanced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= PTR_RESET;
      end else if (take && !strict) begin
         rr_ptr <= grant_idx;
      end
   end

   // One-entry output register. It captures the head data of the granted
   // queue on a pop; otherwise it empties when downstream accepts and
   // keeps its last id/data so the outputs do not toggle needlessly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_prt  <= '0;
         out_dout <= '0;
      end else if (take) begin
         out_vld  <= 1'b1;
         out_prt  <= grant_idx;
         out_dout <= buf_po_dout;
      end else if (out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_static_buff_sched.sv
// ---------------------------------------------------------------------------
// tb_static_buff_sched
//
// Self-checking bench for static_buff_sched. It contains a simple model of
// the external multi-FIFO buffer (driven by the DUT strobes) and a queue
// based reference model of the scheduler. Expected output entries go into a
// scoreboard queue; a monitor pops and compares them on every output
// handshake. Honours SCHED_STRICT_PRIO_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_static_buff_sched;
   import static_buff_pkg::*;

   localparam int NUMELEM = DEF_NUMELEM;
   localparam int BITDATA = DEF_BITDATA;
   localparam int NUMFIFO = DEF_NUMFIFO;
   localparam int BITFIFO = idx_bits(NUMFIFO);

   typedef struct packed {
      logic [BITFIFO-1:0] prt;
      logic [BITDATA-1:0] dout;
   } exp_t;

   logic               clk;
   logic               rst;
   logic               buf_ready;
   logic               in_vld;
   logic [BITFIFO-1:0] in_prt;
   logic [BITDATA-1:0] in_din;
   logic               in_rdy;
   logic               buf_push;
   logic [BITFIFO-1:0] buf_pu_prt;
   logic [BITDATA-1:0] buf_pu_din;
   logic               buf_pop;
   logic [BITFIFO-1:0] buf_po_prt;
   logic [BITDATA-1:0] buf_po_dout;
   logic               out_vld;
   logic               out_rdy;
   logic [BITFIFO-1:0] out_prt;
   logic [BITDATA-1:0] out_dout;
   logic [NUMFIFO-1:0] q_empty;
   logic [NUMFIFO-1:0] q_full;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];

   // External buffer model: circular storage per queue
   logic [BITDATA-1:0] bmem [NUMFIFO][NUMELEM];
   int                 bhd  [NUMFIFO];
   int                 bsz  [NUMFIFO];

   // Reference model state: per-queue contents, output entry, pointer
   logic [BITDATA-1:0] mdat [NUMFIFO][NUMELEM];
   int                 mhd  [NUMFIFO];
   int                 msz  [NUMFIFO];
   int                 mptr;
   logic               mvld;
   logic [BITFIFO-1:0] mprt;
   logic [BITDATA-1:0] mdout;

   // DUT strobes captured before an edge, applied to the buffer after it
   logic               cap_push;
   logic [BITFIFO-1:0] cap_pu_prt;
   logic [BITDATA-1:0] cap_pu_din;
   logic               cap_pop;
   logic [BITFIFO-1:0] cap_po_prt;

   static_buff_sched #(
      .NUMELEM (NUMELEM),
      .BITDATA (BITDATA),
      .NUMFIFO (NUMFIFO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .buf_ready   (buf_ready),
      .in_vld      (in_vld),
      .in_prt      (in_prt),
      .in_din      (in_din),
      .in_rdy      (in_rdy),
      .buf_push    (buf_push),
      .buf_pu_prt  (buf_pu_prt),
      .buf_pu_din  (buf_pu_din),
      .buf_pop     (buf_pop),
      .buf_po_prt  (buf_po_prt),
      .buf_po_dout (buf_po_dout),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .out_prt     (out_prt),
      .out_dout    (out_dout),
      .q_empty     (q_empty),
      .q_full      (q_full)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer head data follows the requested pop queue combinationally.
   always_comb begin
      buf_po_dout = '0;
      if (bsz[buf_po_prt] > 0) begin
         buf_po_dout = bmem[buf_po_prt][bhd[buf_po_prt]];
      end
   end

   // Single comparison: counts it and reports a FAIL line on mismatch.
   task automatic compareVal(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Clear buffer model, reference model, captured strobes and scoreboard.
   task automatic clearModels();
      for (int i = 0; i < NUMFIFO; i++) begin
         bhd[i] = 0;
         bsz[i] = 0;
         mhd[i] = 0;
         msz[i] = 0;
      end
      mptr     = NUMFIFO - 1;
      mvld     = 1'b0;
      mprt     = '0;
      mdout    = '0;
      cap_push = 1'b0;
      cap_pop  = 1'b0;
      sb.delete();
   endtask

   // Compare the DUT against the reference model for the current cycle,
   // then advance the model across the coming clock edge.
   task automatic checkOutput();
      logic               exp_in_rdy;
      logic               exp_push;
      logic               exp_take;
      logic [NUMFIFO-1:0] exp_empty;
      logic [NUMFIFO-1:0] exp_full;
      logic [BITDATA-1:0] d;
      int                 g;
      int                 p;
      int                 c;

      p = int'(in_prt);
      exp_in_rdy = buf_ready && (p < NUMFIFO) && (msz[p] < NUMELEM);
      exp_push   = in_vld && exp_in_rdy;
      for (int i = 0; i < NUMFIFO; i++) begin
         exp_empty[i] = (msz[i] == 0);
         exp_full[i]  = (msz[i] == NUMELEM);
      end
      g = -1;
`ifdef SCHED_STRICT_PRIO_EN
      for (int i = 0; i < NUMFIFO; i++) begin
         if (g < 0 && msz[i] > 0) g = i;
      end
`else
      for (int k = 1; k <= NUMFIFO; k++) begin
         c = (mptr + k) % NUMFIFO;
         if (g < 0 && msz[c] > 0) g = c;
      end
`endif
      exp_take = buf_ready && (g >= 0) && (!mvld || out_rdy);

      compareVal("in_rdy", int'(in_rdy), int'(exp_in_rdy));
      compareVal("buf_push", int'(buf_push), int'(exp_push));
      compareVal("buf_pop", int'(buf_pop), int'(exp_take));
      if (exp_take) compareVal("buf_po_prt", int'(buf_po_prt), g);
      if (exp_push) compareVal("buf_pu_din", int'(buf_pu_din), int'(in_din));
      compareVal("q_empty", int'(q_empty), int'(exp_empty));
      compareVal("q_full", int'(q_full), int'(exp_full));
      compareVal("out_vld", int'(out_vld), int'(mvld));
      compareVal("out_prt", int'(out_prt), int'(mprt));
      compareVal("out_dout", int'(out_dout), int'(mdout));

      cap_push   = buf_push;
      cap_pu_prt = buf_pu_prt;
      cap_pu_din = buf_pu_din;
      cap_pop    = buf_pop;
      cap_po_prt = buf_po_prt;

      if (exp_take) begin
         d      = mdat[g][mhd[g]];
         mhd[g] = (mhd[g] + 1) % NUMELEM;
         msz[g] = msz[g] - 1;
         mvld   = 1'b1;
         mprt   = BITFIFO'(g);
         mdout  = d;
         sb.push_back('{prt: BITFIFO'(g), dout: d});
`ifndef SCHED_STRICT_PRIO_EN
         mptr = g;
`endif
      end else if (out_rdy) begin
         mvld = 1'b0;
      end
      if (exp_push) begin
         mdat[p][(mhd[p] + msz[p]) % NUMELEM] = in_din;
         msz[p] = msz[p] + 1;
      end
   endtask

   // One clock cycle: update the buffer model with the strobes of the last
   // cycle, drive new inputs away from the edge, then check.
   task automatic applyStimulus(input logic vld, input int prt, input int din,
                                input logic brdy, input logic ordy);
      int bp;
      @(posedge clk);
      #1;
      if (cap_pop) begin
         bp      = int'(cap_po_prt);
         if (bsz[bp] > 0) begin
            bhd[bp] = (bhd[bp] + 1) % NUMELEM;
            bsz[bp] = bsz[bp] - 1;
         end
      end
      if (cap_push) begin
         bp = int'(cap_pu_prt);
         if (bsz[bp] < NUMELEM) begin
            bmem[bp][(bhd[bp] + bsz[bp]) % NUMELEM] = cap_pu_din;
            bsz[bp] = bsz[bp] + 1;
         end
      end
      in_vld    = vld;
      in_prt    = BITFIFO'(prt);
      in_din    = BITDATA'(din);
      buf_ready = brdy;
      out_rdy   = ordy;
      #1;
      checkOutput();
   endtask

   // Assert reset mid-cycle; the design must clear at once, before any edge.
   task automatic doReset();
      @(posedge clk);
      #1;
      in_vld    = 1'b0;
      in_prt    = '0;
      in_din    = '0;
      buf_ready = 1'b1;
      out_rdy   = 1'b1;
      rst       = 1'b1;
      clearModels();
      #1;
      compareVal("rst_out_vld", int'(out_vld), 0);
      compareVal("rst_q_empty", int'(q_empty), (1 << NUMFIFO) - 1);
      compareVal("rst_q_full", int'(q_full), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: every accepted output entry must match the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_vld && out_rdy) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_underflow: got prt=%0d dout=%0d expected no entry",
                     out_prt, out_dout);
         end else begin
            e = sb.pop_front();
            compareVal("mon_out_prt", int'(out_prt), int'(e.prt));
            compareVal("mon_out_dout", int'(out_dout), int'(e.dout));
         end
      end
   end

   initial begin
      rst       = 1'b1;
      buf_ready = 1'b1;
      in_vld    = 1'b0;
      in_prt    = '0;
      in_din    = '0;
      out_rdy   = 1'b1;
      clearModels();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] idle after reset");
      repeat (3) applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

      $display("[TB] stream 1..4 into queue 3");
      for (int v = 1; v <= 4; v++) applyStimulus(1'b1, 3, v, 1'b1, 1'b1);
      repeat (4) applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

      $display("[TB] fill queue 3 behind a stalled output");
      for (int v = 1; v <= 6; v++) applyStimulus(1'b1, 3, v + 8, 1'b1, 1'b0);
      repeat (8) applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

      $display("[TB] queues 0,2,5 with two entries each");
      applyStimulus(1'b1, 7, 15, 1'b1, 1'b1);
      applyStimulus(1'b1, 0, 1, 1'b1, 1'b0);
      applyStimulus(1'b1, 0, 2, 1'b1, 1'b0);
      applyStimulus(1'b1, 2, 3, 1'b1, 1'b0);
      applyStimulus(1'b1, 2, 4, 1'b1, 1'b0);
      applyStimulus(1'b1, 5, 5, 1'b1, 1'b0);
      applyStimulus(1'b1, 5, 6, 1'b1, 1'b0);
      repeat (5) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
      repeat (10) applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

      $display("[TB] full queue 1 with simultaneous pop and push");
      for (int v = 1; v <= 5; v++) applyStimulus(1'b1, 1, v, 1'b1, 1'b0);
      applyStimulus(1'b1, 1, 6, 1'b1, 1'b1);
      applyStimulus(1'b1, 1, 7, 1'b1, 1'b1);
      repeat (8) applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

      $display("[TB] buffer not ready");
      applyStimulus(1'b1, 4, 8, 1'b1, 1'b0);
      applyStimulus(1'b1, 4, 9, 1'b0, 1'b0);
      applyStimulus(1'b1, 6, 10, 1'b0, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

      $display("[TB] reset mid-stream");
      applyStimulus(1'b1, 2, 1, 1'b1, 1'b0);
      applyStimulus(1'b1, 4, 2, 1'b1, 1'b0);
      applyStimulus(1'b1, 6, 3, 1'b1, 1'b0);
      applyStimulus(1'b1, 2, 4, 1'b1, 1'b0);
      applyStimulus(1'b1, 4, 5, 1'b1, 1'b0);
      doReset();
      applyStimulus(1'b1, 6, 9, 1'b1, 1'b1);
      repeat (4) applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, NUMFIFO - 1)),
                       int'($urandom_range(0, 15)), $urandom_range(0, 9) != 0,
                       $urandom_range(0, 9) < 7);
      end

      $display("[TB] drain");
      repeat (50) applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
      compareVal("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
